// File: rtl/maze_dfs_controller.sv
// ----------------------------------------------------------------------------
// maze_dfs_controller
//
// Depth-first search over a 16x16 one-bit maze memory (0 = free, 1 = wall or
// already visited). Each entered cell is marked visited by writing 1 to it.
// Moves taken are kept on an internal stack so dead ends can be unwound.
// After the goal is reached, the stack is streamed out from the bottom,
// giving the path from start to goal as 2-bit moves.
//
// Move encoding: 0 up (Y+1), 1 right (X+1), 2 left (X-1), 3 down (Y-1).
//
// Ports:
//   Clk        in   rising-edge clock
//   our_reset  in   synchronous active-high reset
//   Start      in   one-cycle run request, honoured only while idle
//   MemDout    in   maze read data, combinational from MemX/MemY/MemRd
//   MemX/MemY  out  maze column/row address (current cell unless probing)
//   MemRd      out  maze read enable
//   MemWr      out  maze write enable
//   MemDin     out  maze write data (1 whenever MemWr)
//   Busy       out  search in progress
//   Done       out  path found (level, terminal)
//   Fail       out  no path exists (level, terminal)
//   Move       out  current path move
//   MoveValid  out  Move is valid
//   MoveReady  in   consumer accepts Move
//   PathLen    out  number of moves in the found path
//   DbgState   out  current FSM state encoding, for observation only
//
// Path stream handshake: a move transfers on a rising Clk edge where both
// MoveValid and MoveReady are 1. While MoveValid=1 and MoveReady=0, Move is
// held stable and MoveValid stays high; MoveValid never depends on MoveReady.
// ----------------------------------------------------------------------------
module maze_dfs_controller #(
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int GOAL_X      = 15,
    parameter int GOAL_Y      = 15,
    parameter int STACK_DEPTH = 256
) (
    input  logic       Clk,
    input  logic       our_reset,
    input  logic       Start,
    input  logic       MemDout,
    output logic [3:0] MemX,
    output logic [3:0] MemY,
    output logic       MemRd,
    output logic       MemWr,
    output logic       MemDin,
    output logic       Busy,
    output logic       Done,
    output logic       Fail,
    output logic [1:0] Move,
    output logic       MoveValid,
    input  logic       MoveReady,
    output logic [8:0] PathLen,
    output logic [2:0] DbgState
);

    localparam int SW = $clog2(STACK_DEPTH);

    localparam logic [3:0] START_X4 = 4'(START_X);
    localparam logic [3:0] START_Y4 = 4'(START_Y);
    localparam logic [3:0] GOAL_X4  = 4'(GOAL_X);
    localparam logic [3:0] GOAL_Y4  = 4'(GOAL_Y);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_MARK      = 3'd2,
        S_PROBE     = 3'd3,
        S_BACKTRACK = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_cur_x;
    logic [3:0]  r_cur_y;
    logic [2:0]  r_dir;
    logic [8:0]  r_sp;
    logic [8:0]  r_rp;
    logic [1:0]  r_stack [STACK_DEPTH];

    logic [3:0]  w_nb_x;
    logic [3:0]  w_nb_y;
    logic        w_nb_ok;
    logic        w_probing;
    logic        w_push;
    logic [SW-1:0] w_top_idx;
    logic [1:0]  w_top;
    logic [3:0]  w_back_x;
    logic [3:0]  w_back_y;
    logic        w_at_goal;
    logic        w_move_valid;

    assign DbgState = r_state;

    // Neighbour of the current cell in direction r_dir. w_nb_ok is low when
    // the step would wrap off the 0..15 grid, or when all four directions
    // have been tried (r_dir == 4).
    always_comb begin
        w_nb_x  = r_cur_x;
        w_nb_y  = r_cur_y;
        w_nb_ok = 1'b0;
        case (r_dir)
            3'd0: begin
                w_nb_y  = r_cur_y + 4'd1;
                w_nb_ok = (r_cur_y != 4'd15);
            end
            3'd1: begin
                w_nb_x  = r_cur_x + 4'd1;
                w_nb_ok = (r_cur_x != 4'd15);
            end
            3'd2: begin
                w_nb_x  = r_cur_x - 4'd1;
                w_nb_ok = (r_cur_x != 4'd0);
            end
            3'd3: begin
                w_nb_y  = r_cur_y - 4'd1;
                w_nb_ok = (r_cur_y != 4'd0);
            end
            default: ;
        endcase
    end

    // Top-of-stack move and the cell we came from before taking it.
    assign w_top_idx = r_sp[SW-1:0] - SW'(1);
    assign w_top     = r_stack[w_top_idx];

    always_comb begin
        w_back_x = r_cur_x;
        w_back_y = r_cur_y;
        case (w_top)
            2'd0:    w_back_y = r_cur_y - 4'd1;
            2'd1:    w_back_x = r_cur_x - 4'd1;
            2'd2:    w_back_x = r_cur_x + 4'd1;
            default: w_back_y = r_cur_y + 4'd1;
        endcase
    end

    assign w_probing    = (r_state == S_PROBE) && (r_dir != 3'd4) && w_nb_ok;
    assign w_push       = w_probing && !MemDout && !our_reset;
    assign w_at_goal    = (r_cur_x == GOAL_X4) && (r_cur_y == GOAL_Y4);
    assign w_move_valid = (r_state == S_DONE) && (r_rp < r_sp);

    // ---------------- state register ----------------
    always_ff @(posedge Clk) begin
        if (our_reset) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (Start) w_state_nxt = S_CHECK;
            S_CHECK:     w_state_nxt = MemDout ? S_FAIL : S_MARK;
            S_MARK:      w_state_nxt = w_at_goal ? S_DONE : S_PROBE;
            S_PROBE: begin
                if (r_dir == 3'd4)            w_state_nxt = S_BACKTRACK;
                else if (w_nb_ok && !MemDout) w_state_nxt = S_MARK;
            end
            S_BACKTRACK: w_state_nxt = (r_sp == 9'd0) ? S_FAIL : S_PROBE;
            default:     w_state_nxt = r_state;
        endcase
    end

    // ---------------- outputs ----------------
    // Memory strobes are masked during reset so the reset cycle never
    // touches the maze.
    always_comb begin
        MemX      = r_cur_x;
        MemY      = r_cur_y;
        MemRd     = 1'b0;
        MemWr     = 1'b0;
        MemDin    = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Fail      = 1'b0;
        Move      = 2'd0;
        MoveValid = 1'b0;
        PathLen   = 9'd0;
        case (r_state)
            S_CHECK: begin
                Busy  = 1'b1;
                MemRd = !our_reset;
            end
            S_MARK: begin
                Busy   = 1'b1;
                MemWr  = !our_reset;
                MemDin = !our_reset;
            end
            S_PROBE: begin
                Busy = 1'b1;
                if (w_probing) begin
                    MemX  = w_nb_x;
                    MemY  = w_nb_y;
                    MemRd = !our_reset;
                end
            end
            S_BACKTRACK: Busy = 1'b1;
            S_DONE: begin
                Done      = 1'b1;
                PathLen   = r_sp;
                MoveValid = w_move_valid;
                if (w_move_valid) Move = r_stack[r_rp[SW-1:0]];
            end
            S_FAIL:  Fail = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge Clk) begin
        if (our_reset) begin
            r_cur_x <= 4'd0;
            r_cur_y <= 4'd0;
            r_dir   <= 3'd0;
            r_sp    <= 9'd0;
            r_rp    <= 9'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_cur_x <= START_X4;
                        r_cur_y <= START_Y4;
                        r_dir   <= 3'd0;
                        r_sp    <= 9'd0;
                        r_rp    <= 9'd0;
                    end
                end
                S_MARK: r_dir <= 3'd0;
                S_PROBE: begin
                    if (r_dir != 3'd4) begin
                        if (w_nb_ok && !MemDout) begin
                            r_sp    <= r_sp + 9'd1;
                            r_cur_x <= w_nb_x;
                            r_cur_y <= w_nb_y;
                        end else begin
                            r_dir <= r_dir + 3'd1;
                        end
                    end
                end
                S_BACKTRACK: begin
                    // Resume probing just past the direction that led here;
                    // a popped "down" yields dir=4, forcing another pop.
                    if (r_sp != 9'd0) begin
                        r_sp    <= r_sp - 9'd1;
                        r_cur_x <= w_back_x;
                        r_cur_y <= w_back_y;
                        r_dir   <= {1'b0, w_top} + 3'd1;
                    end
                end
                S_DONE: begin
                    if (w_move_valid && MoveReady) r_rp <= r_rp + 9'd1;
                end
                default: ;
            endcase
        end
    end

    // Move stack: contents are don't-care after reset, so no reset here.
    always_ff @(posedge Clk) begin
        if (w_push) r_stack[r_sp[SW-1:0]] <= r_dir[1:0];
    end

endmodule

// File: tb/tb_maze_dfs_controller.sv
module tb_maze_dfs_controller;

    logic       Clk = 1'b0;
    logic       our_reset;
    logic       Start;
    logic       MemDout;
    logic [3:0] MemX;
    logic [3:0] MemY;
    logic       MemRd;
    logic       MemWr;
    logic       MemDin;
    logic       Busy;
    logic       Done;
    logic       Fail;
    logic [1:0] Move;
    logic       MoveValid;
    logic       MoveReady;
    logic [8:0] PathLen;
    logic [2:0] DbgState;

    maze_dfs_controller dut (
        .Clk       (Clk),
        .our_reset (our_reset),
        .Start     (Start),
        .MemDout   (MemDout),
        .MemX      (MemX),
        .MemY      (MemY),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .MemDin    (MemDin),
        .Busy      (Busy),
        .Done      (Done),
        .Fail      (Fail),
        .Move      (Move),
        .MoveValid (MoveValid),
        .MoveReady (MoveReady),
        .PathLen   (PathLen),
        .DbgState  (DbgState)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- maze memory model ----------------
    logic [255:0] maze;
    logic [255:0] load_val;
    logic         load_en;

    always @(posedge Clk) begin
        if (load_en)    maze <= load_val;
        else if (MemWr) maze[{MemY, MemX}] <= 1'b1;
    end
    assign MemDout = MemRd ? maze[{MemY, MemX}] : 1'b0;

    // ---------------- scoreboard ----------------
    int         n_vec  = 0;
    int         n_miss = 0;
    logic [1:0] exp_q[$];
    bit         stream_on = 0;
    bit         mon_on    = 0;
    int         n_got;
    int         n_wr;
    bit         prev_stall = 0;
    logic [1:0] prev_move  = 2'd0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (mon_on) begin
            check("rd_wr_exclusive", int'(MemRd & MemWr), 0);
            check("din_eq_wr", int'(MemDin), int'(MemWr));
            if (MemWr) n_wr++;
        end
        if (stream_on) begin
            if (prev_stall) begin
                check("stall_valid_held", int'(MoveValid), 1);
                check("stall_move_held", int'(Move), int'(prev_move));
            end
            if (MoveValid && MoveReady) begin
                n_got++;
                if (exp_q.size() == 0) begin
                    check("extra_move", n_got, 0);
                end else begin
                    check("move_data", int'(Move), int'(exp_q.pop_front()));
                end
            end
            prev_stall = MoveValid && !MoveReady;
            prev_move  = Move;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- reference DFS ----------------
    logic [255:0] m_vis;
    int           m_path[$];
    bit           m_ok;

    function automatic int dx(input int d);
        return (d == 1) ? 1 : ((d == 2) ? -1 : 0);
    endfunction

    function automatic int dy(input int d);
        return (d == 0) ? 1 : ((d == 3) ? -1 : 0);
    endfunction

    task automatic model_run();
        int cx, cy, d, nx, ny;
        bit found;
        m_vis = load_val;
        m_path.delete();
        cx = 0; cy = 0; d = 0; nx = 0; ny = 0;
        if (m_vis[0]) begin
            m_ok = 0;
            return;
        end
        m_vis[0] = 1'b1;
        forever begin
            if (cx == 15 && cy == 15) begin
                m_ok = 1;
                return;
            end
            found = 0;
            while (d < 4 && !found) begin
                nx = cx + dx(d);
                ny = cy + dy(d);
                if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !m_vis[ny*16+nx]) found = 1;
                else d++;
            end
            if (found) begin
                m_path.push_back(d);
                cx = nx; cy = ny;
                m_vis[cy*16+cx] = 1'b1;
                d = 0;
            end else if (m_path.size() == 0) begin
                m_ok = 0;
                return;
            end else begin
                d  = m_path.pop_back();
                cx = cx - dx(d);
                cy = cy - dy(d);
                d  = d + 1;
            end
        end
    endtask

    // ---------------- maze construction ----------------
    // kind 0 all free, 1 origin walled, 2 dead-end corridor, 3 goal walled in,
    // 4 random 25% walls.
    task automatic build_maze(input int kind);
        load_val = '0;
        case (kind)
            1: load_val[0] = 1'b1;
            2: begin
                for (int x = 1; x <= 14; x++) load_val[16 + x] = 1'b1;
                for (int y = 2; y <= 5; y++)  load_val[y*16 + 1] = 1'b1;
                load_val[6*16 + 0] = 1'b1;
            end
            3: begin
                load_val[15*16 + 14] = 1'b1;
                load_val[14*16 + 15] = 1'b1;
            end
            4: begin
                for (int i = 0; i < 256; i++) load_val[i] = ($urandom_range(0, 3) == 0);
                load_val[0]   = 1'b0;
                load_val[255] = 1'b0;
            end
            default: ;
        endcase
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(posedge Clk); #1;
        our_reset = 1'b1;
        Start     = 1'b0;
        MoveReady = 1'b0;
        load_en   = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        our_reset = 1'b0;
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    typedef struct {
        int kind;
        int rdy_mode;   // 0 always, 1 pattern 1-0-0-1, 2 random
        bit use_model;  // expected path/result from the reference DFS
        bit exp_done;
        int exp_len;
        int exp_cyc;    // cycles from Start to Fail/Done, -1 unchecked
        bit chk_nowr;   // no maze write may occur
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int exp_len;
        bit exp_done;
        int k;
        string tag;
        tag = $sformatf("v%0d", idx);
        build_maze(v.kind);
        model_run();
        do_reset();
        check({tag, "_reset_outputs"},
              int'({Busy, Done, Fail, MoveValid, MemRd, MemWr, MemDin, Move, PathLen, MemX, MemY}), 0);

        exp_q.delete();
        if (v.use_model) begin
            exp_done = m_ok;
            exp_len  = m_ok ? m_path.size() : 0;
            if (m_ok) foreach (m_path[i]) exp_q.push_back(2'(m_path[i]));
        end else begin
            exp_done = v.exp_done;
            exp_len  = v.exp_len;
            if (v.kind == 0) begin
                repeat (15) exp_q.push_back(2'd0);
                repeat (15) exp_q.push_back(2'd1);
            end else if (v.kind == 2) begin
                repeat (15) exp_q.push_back(2'd1);
                repeat (15) exp_q.push_back(2'd0);
            end
        end

        n_wr   = 0;
        mon_on = 1;
        pulse_start();
        cyc = 1;
        check({tag, "_busy_after_start"}, int'(Busy), int'(!(Done || Fail)));
        while (!(Done || Fail) && cyc < 20000) begin
            @(posedge Clk); #1;
            cyc++;
        end
        check({tag, "_finished"}, int'(Done || Fail), 1);
        if (v.exp_cyc >= 0) check({tag, "_latency"}, cyc, v.exp_cyc);
        check({tag, "_done"}, int'(Done), int'(exp_done));
        check({tag, "_fail"}, int'(Fail), int'(!exp_done));
        check({tag, "_busy_end"}, int'(Busy), 0);
        check({tag, "_pathlen"}, int'(PathLen), exp_len);

        n_got     = 0;
        stream_on = 1;
        k = 0;
        while (k < 2000) begin
            @(posedge Clk); #1;
            case (v.rdy_mode)
                0:       MoveReady = 1'b1;
                1:       MoveReady = ((k % 4) == 0) || ((k % 4) == 3);
                default: MoveReady = ($urandom_range(0, 1) == 1);
            endcase
            k++;
            @(negedge Clk); #1;
            if (exp_q.size() == 0 && !MoveValid) break;
        end
        stream_on = 0;
        MoveReady = 1'b0;
        mon_on    = 0;
        check({tag, "_moves_left"}, exp_q.size(), 0);
        check({tag, "_moves_got"}, n_got, exp_len);
        check({tag, "_valid_end"}, int'(MoveValid), 0);
        if (v.chk_nowr) check({tag, "_no_writes"}, n_wr, 0);
        if (maze !== m_vis) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_maze: got %h expected %h", tag, maze, m_vis);
        end else begin
            n_vec++;
        end
    endtask

    vec_t vecs[8];

    // ---------------- main ----------------
    initial begin
        int w;
        our_reset = 1'b1;
        Start     = 1'b0;
        MoveReady = 1'b0;
        load_en   = 1'b1;
        load_val  = '0;

        vecs[0] = '{kind: 0, rdy_mode: 0, use_model: 0, exp_done: 1, exp_len: 30, exp_cyc: -1, chk_nowr: 0};
        vecs[1] = '{kind: 1, rdy_mode: 0, use_model: 0, exp_done: 0, exp_len: 0,  exp_cyc: 2,  chk_nowr: 1};
        vecs[2] = '{kind: 2, rdy_mode: 2, use_model: 0, exp_done: 1, exp_len: 30, exp_cyc: -1, chk_nowr: 0};
        vecs[3] = '{kind: 3, rdy_mode: 0, use_model: 0, exp_done: 0, exp_len: 0,  exp_cyc: -1, chk_nowr: 0};
        vecs[4] = '{kind: 0, rdy_mode: 1, use_model: 0, exp_done: 1, exp_len: 30, exp_cyc: -1, chk_nowr: 0};
        vecs[5] = '{kind: 4, rdy_mode: 2, use_model: 1, exp_done: 0, exp_len: 0,  exp_cyc: -1, chk_nowr: 0};
        vecs[6] = '{kind: 4, rdy_mode: 1, use_model: 1, exp_done: 0, exp_len: 0,  exp_cyc: -1, chk_nowr: 0};
        vecs[7] = '{kind: 4, rdy_mode: 2, use_model: 1, exp_done: 0, exp_len: 0,  exp_cyc: -1, chk_nowr: 0};

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of PROBE.
        build_maze(0);
        do_reset();
        pulse_start();
        w = 0;
        while (DbgState != 3'd3 && w < 50) begin
            @(posedge Clk); #1;
            w++;
        end
        check("midrst_reached_probe", int'(Busy), 1);
        our_reset = 1'b1;
        @(negedge Clk);
        check("midrst_no_rd", int'(MemRd), 0);
        check("midrst_no_wr", int'(MemWr), 0);
        @(posedge Clk); #1;
        our_reset = 1'b0;
        check("midrst_busy", int'(Busy), 0);
        check("midrst_done_fail", int'({Done, Fail}), 0);
        check("midrst_mem", int'({MemRd, MemWr}), 0);

        // Fresh reset and run reproduces the full result.
        run_vec(vecs[0], 8);

        // Start is ignored once DONE.
        pulse_start();
        repeat (3) @(posedge Clk);
        #1;
        check("done_start_ignored_done", int'(Done), 1);
        check("done_start_ignored_busy", int'(Busy), 0);
        check("done_start_ignored_len", int'(PathLen), 30);

        // Start coincident with reset: reset wins.
        our_reset = 1'b1;
        Start     = 1'b1;
        @(posedge Clk); #1;
        our_reset = 1'b0;
        Start     = 1'b0;
        check("rst_start_busy0", int'(Busy), 0);
        @(posedge Clk); #1;
        check("rst_start_busy1", int'(Busy), 0);
        check("rst_start_done", int'(Done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/maze_dfs_controller.md
Name: maze_dfs_controller

Overview:
- Sequences the 16x16 one-bit maze memory (0 = free, 1 = wall/visited) to find a path from start cell to goal cell by depth-first search, using an internal move stack.
- Marks each entered cell visited by writing 1 to it, and backtracks on dead ends.
- After success, streams the found path as 2-bit moves over a valid/ready handshake.
- Sits between top-level control and the maze memory; it is the memory's only master during a run.

Parameters:
- START_X, 0, start column (0..15)
- START_Y, 0, start row (0..15)
- GOAL_X, 15, goal column
- GOAL_Y, 15, goal row
- STACK_DEPTH, 256, move-stack entries; covers every possible path

Ports:
- Clk  in  1  clock, rising edge
- our_reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle run request, honoured only in IDLE
- MemDout  in  1  maze read data, combinational from MemX/MemY/MemRd
- MemX  out  4  maze column address
- MemY  out  4  maze row address
- MemRd  out  1  maze read enable
- MemWr  out  1  maze write enable
- MemDin  out  1  maze write data, always 1 when MemWr
- Busy  out  1  search in progress
- Done  out  1  path found, level
- Fail  out  1  no path exists, level
- Move  out  2  path move: 0 up (Y+1), 1 right (X+1), 2 left (X-1), 3 down (Y-1)
- MoveValid  out  1  Move valid
- MoveReady  in  1  consumer accepts Move
- PathLen  out  9  number of moves in found path

Behaviour:
- One clock; reset is synchronous and active-high (our_reset sampled on rising Clk). All outputs 0 after reset; state IDLE; sp=0; dir=0; rp=0.
- Registers: cur (X,Y 4b each); dir (3b, 0..4); sp (9b); rp (9b); stack[STACK_DEPTH] of 2b moves.
- Default outputs each cycle: MemRd=0, MemWr=0, MemDin=0, MemX/MemY=cur.
- IDLE: on Start → cur=START, sp=0, dir=0 → CHECK. Busy=0.
- CHECK: MemRd=1 at cur; sample MemDout same cycle. 1 → FAIL; 0 → MARK.
- MARK: MemWr=1, MemDin=1 at cur, one cycle. If cur==GOAL → DONE, else → PROBE with dir=0.
- PROBE, one cycle per direction:
  - dir==4 → BACKTRACK.
  - Neighbour = cur+step(dir).
  - Out of range (X or Y would leave 0..15, i.e. wrap) → no read; dir++.
  - Otherwise MemX/MemY=neighbour, MemRd=1, sample MemDout same cycle.
  - MemDout==0 → stack[sp]=dir, sp++, cur=neighbour → MARK.
  - MemDout==1 → dir++.
- BACKTRACK:
  - sp==0 → FAIL.
  - Else d=stack[sp-1], sp--, cur=cur-step(d), dir=d+1 → PROBE.
  - d==3 gives dir=4, which triggers an immediate further backtrack.
- Busy=1 in CHECK, MARK, PROBE, BACKTRACK.
- DONE:
  - Done=1, PathLen=sp.
  - MoveValid=1 while rp<sp; Move=stack[rp], in path order from start.
  - rp++ on MoveValid&MoveReady.
  - Move held stable while MoveValid&!MoveReady.
  - rp==sp → MoveValid=0. sp==0 (start==goal) → no moves.
- FAIL: Fail=1, PathLen=0, MoveValid=0.
- DONE and FAIL are terminal. Start is ignored outside IDLE, and only our_reset returns to IDLE; the maze memory needs the same reset to clear visited marks before a rerun.
- Reset mid-search or mid-stream: immediate return to IDLE next edge; no Mem access in the reset cycle; stack contents don't-care.
- Neither MemRd and MemWr is ever asserted in the same cycle.
- Simultaneous Start and our_reset: reset wins.

Test Plan:
- All-free maze, Start pulse → Done=1, PathLen=30, streamed moves 15×up then 15×right; maze cells (0,0..15) and (1..15,15) read back 1.
- Cell (0,0)=1, Start → Fail=1 two cycles after Start; no MemWr ever asserted.
- Maze with a dead-end corridor up column 0 to (0,5), open route via row 0 to column 15 then up → Done; PathLen=30; path contains no up moves at X=0 beyond the dead end; backtrack exercised.
- Goal walled in ((14,15) and (15,14)=1), rest free → Fail=1, Done=0; every reachable free cell marked 1.
- Successful run with MoveReady toggling 1-0-0-1 → Move stable while stalled; each of 30 moves delivered exactly once, in order.
- our_reset asserted mid-PROBE → next cycle Busy=0, Done=Fail=0, MemRd=MemWr=0; fresh reset+Start reproduces full result.
